// File: rtl/arb_mux_nto1.sv
// N-to-1 arbitrating mux: round-robin or fixed-priority grant across
// valid/ready channels, with the winning word held in an output register.
module arb_mux_nto1 #(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_CH     = 4,
    localparam int SEL_WIDTH  = $clog2(NUM_CH)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
    input  logic [NUM_CH-1:0]            i_valid,
    output logic [NUM_CH-1:0]            o_ready,
    input  logic                         i_mode,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic [SEL_WIDTH-1:0]         o_sel,
    output logic                         o_valid,
    input  logic                         i_ready
);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic                  valid_q, valid_d;
    logic [SEL_WIDTH-1:0]  ptr_q, ptr_d;

    logic [NUM_CH-1:0]     grant;
    logic [SEL_WIDTH-1:0]  gnt_idx;
    logic [SEL_WIDTH-1:0]  cidx;
    logic                  found;
    logic                  load_en;
    logic                  xfer;
    int                    idx;

    // Search order starts at ptr in RR mode, at 0 in fixed mode.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        cidx    = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx  = i_mode ? i : (int'(ptr_q) + i) % NUM_CH;
            cidx = SEL_WIDTH'(idx);
            if (!found && i_valid[cidx]) begin
                found         = 1'b1;
                grant[cidx]   = 1'b1;
                gnt_idx       = cidx;
            end
        end
    end

    assign load_en = !valid_q || i_ready;
    assign o_ready = (!i_rst && load_en) ? grant : '0;
    assign xfer    = !i_rst && load_en && found;

    always_comb begin
        data_d  = data_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (xfer) begin
            data_d  = i_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
            sel_d   = gnt_idx;
            valid_d = 1'b1;
            if (!i_mode) begin
                // Wrap at NUM_CH, not at the power of two above it.
                if (int'(gnt_idx) == NUM_CH - 1) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = gnt_idx + 1'b1;
                end
            end
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign o_data  = data_q;
    assign o_sel   = sel_q;
    assign o_valid = valid_q;

endmodule

// File: doc/arb_mux_nto1.md
# arb_mux_nto1

Parametrised N-to-1 arbitrating multiplexer with a registered output and valid/ready handshakes on every channel. Several producers compete for one consumer, for example CPU data-memory port versus debug/loader unit, or multiple writeback sources. The block selects one channel per transfer with round-robin or fixed-priority arbitration and holds the selected word in an output register until the consumer accepts it. It is the sequential, N-channel generalisation of the combinational 4:1 data mux used in the datapath.

## Interface
Parameters:
- DATA_WIDTH, 32, width of each channel's data word
- NUM_CH, 4, number of input channels; must be ≥ 2 and need not be a power of two
- SEL_WIDTH (localparam), $clog2(NUM_CH), width of the channel index

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  reset, synchronous and active-high
- i_data  in  NUM_CH*DATA_WIDTH  flattened inputs; channel k at [k*DATA_WIDTH +: DATA_WIDTH]
- i_valid  in  NUM_CH  per-channel request; bit k means i_data channel k is valid
- o_ready  out  NUM_CH  per-channel accept; at most one bit high (one-hot or zero)
- i_mode  in  1  arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins)
- o_data  out  DATA_WIDTH  registered selected word
- o_sel  out  SEL_WIDTH  index of the channel that produced o_data
- o_valid  out  1  o_data/o_sel hold an unconsumed word
- i_ready  in  1  consumer accepts o_data when o_valid & i_ready

## Operation
- Output register states:
  - EMPTY (o_valid=0).
  - FULL (o_valid=1).
- Load enable: load_en = !o_valid | i_ready.
- Grant:
  - Computed combinationally from i_valid, i_mode and priority pointer ptr (SEL_WIDTH bits).
  - RR mode: the first requesting channel searching ptr, ptr+1, … wrapping modulo NUM_CH.
  - Fixed mode: the lowest requesting index.
- o_ready[k] = !i_rst & load_en & grant[k]. A transfer from channel k occurs when i_valid[k] & o_ready[k].
- On a transfer:
  - o_data ← channel k data.
  - o_sel ← k.
  - o_valid ← 1.
- Otherwise, when o_valid & i_ready, o_valid ← 0. o_data and o_sel hold their last values.
- When FULL and !i_ready, o_data, o_sel and o_valid hold stable. All o_ready are 0.
- Pointer rules:
  - Updated only on a transfer in RR mode: ptr ← k+1, wrapping to 0 when k = NUM_CH-1 (not at 2^SEL_WIDTH).
  - Fixed mode never modifies ptr.
- Transitions:
  - EMPTY→FULL on a transfer.
  - FULL→FULL on (i_ready & transfer) or !i_ready.
  - FULL→EMPTY on i_ready & no request.
  - EMPTY→EMPTY when no request.
- Reset values: o_valid=0, o_data=0, o_sel=0, ptr=0. o_ready=0 while i_rst is high.
- Reset mid-operation: a held, unconsumed word is discarded, and ptr returns to 0.
- An i_mode change takes effect at the next grant computation. It never alters a word already in the output register.
- A requester may drop i_valid before being granted. No word is taken and nothing is recorded.

## Timing
- Latency: 1 cycle from transfer (i_valid[k] & o_ready[k] at edge n) to o_valid=1 with that data after edge n.
- Throughput: one word per cycle while i_ready is held high. Consume and reload happen in the same cycle with no bubble.
- o_ready depends combinationally on i_valid, i_mode, i_ready and state.
- i_ready does not depend on o_ready in any direction; there is no combinational loop inside the block.
- Arbitration is settled per cycle. A channel granted but stalled (i_ready=0, FULL) gets no o_ready and is re-arbitrated next cycle.

## Test plan
- Reset: assert i_rst for 2 cycles with all i_valid=1.
  - Required: o_valid=0, o_data=0, o_sel=0, o_ready=0 throughout.
  - First transfer after release is from channel 0.
- RR fairness: NUM_CH=4, all i_valid=1, i_ready=1, channel k data = 0xA0+k.
  - Required: o_sel sequence 0,1,2,3,0 on consecutive cycles.
  - o_data 0xA0..0xA3; one o_ready bit per cycle.
- Fixed priority: i_mode=1, i_valid=4'b1010, i_ready=1.
  - Required: o_sel=1 every cycle and o_ready=4'b0010.
  - Then drop i_valid[1]: required o_sel=3.
- Backpressure: load channel 2 data 0xDEADBEEF, then hold i_ready=0 for 5 cycles with all channels valid.
  - Required: o_data/o_sel/o_valid stable and o_ready=0.
  - Raising i_ready produces the consume and the next load in the same cycle.
- Non-power-of-two wrap: NUM_CH=3, only channel 2 valid, then all valid.
  - Required: after the grant to 2, ptr wraps to 0, so the next o_sel is 0, then 1.
- Reset mid-operation: FULL with o_data=0x1234, i_ready=0. Assert i_rst for 1 cycle.
  - Required: o_valid=0, o_data=0.
  - Word 0x1234 never handshaked out.
